// File: rtl/ccu_ctrl_snoop_unit.sv
// -----------------------------------------------------------------------------
// ccu_ctrl_snoop_unit
//
// Snoop-data unit of the CCU control path. Once the control decoder resolves a
// snooped read, this block either forwards the cache line of the first
// data-carrying snoop responder onto the initiator's R channel (with ACE
// IsShared/PassDirty in resp[3:2]) or returns a single-beat acknowledge for an
// invalidating read. CD data from every other responder that announced a data
// transfer is accepted and discarded, so no snooped master is left stalled.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   su_valid_i/su_ready_o operation handshake from the decoder
//   su_op_i               READ_SNP_DATA or SEND_INVALID_ACK_R
//   ccu_req_holder_i      held initiator request (ar.id is used)
//   data_available_i      per-port CR DataTransfer flags
//   first_responder_i     port whose CD data is forwarded
//   shared_i, dirty_i     ORed CR IsShared / PassDirty
//   cd_valid_i/cd_data_i/cd_last_i/cd_ready_o  per-port CD channels
//   r_o, r_valid_o, r_ready_i                  initiator R channel
// -----------------------------------------------------------------------------
package ccu_ctrl_snoop_unit_pkg;

  typedef enum logic [0:0] {
    READ_SNP_DATA      = 1'b0,
    SEND_INVALID_ACK_R = 1'b1
  } su_op_e;

  // Default channel types sized for 4 ports, 4-bit slave IDs, 64-bit data.
  localparam int unsigned DefIdW = 6;

  typedef struct packed {
    logic [DefIdW-1:0] id;
    logic [63:0]       addr;
    logic [7:0]        len;
  } def_ar_chan_t;

  typedef struct packed {
    def_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } def_req_t;

  typedef struct packed {
    logic [DefIdW-1:0] id;
    logic [63:0]       data;
    logic [3:0]        resp;
    logic              last;
  } def_r_chan_t;

endpackage

module ccu_ctrl_snoop_unit
  import ccu_ctrl_snoop_unit_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned NoMstPorts      = 4,
  parameter int unsigned SlvAxiIDWidth   = 4,
  parameter type         mst_req_t       = def_req_t,
  parameter type         mst_r_chan_t    = def_r_chan_t,
  localparam int unsigned MstIdxBits     = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             su_valid_i,
  output logic                             su_ready_o,
  input  su_op_e                           su_op_i,
  input  mst_req_t                         ccu_req_holder_i,
  input  logic [NoMstPorts-1:0]            data_available_i,
  input  logic [MstIdxBits-1:0]            first_responder_i,
  input  logic                             shared_i,
  input  logic                             dirty_i,
  input  logic [NoMstPorts-1:0]            cd_valid_i,
  input  logic [NoMstPorts*AxiDataWidth-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]            cd_last_i,
  output logic [NoMstPorts-1:0]            cd_ready_o,
  output mst_r_chan_t                      r_o,
  output logic                             r_valid_o,
  input  logic                             r_ready_i
);

  localparam int unsigned LineWords = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned CntW      = (LineWords > 1) ? $clog2(LineWords) : 1;
  localparam int unsigned IdWidth   = SlvAxiIDWidth + MstIdxBits;
  localparam logic [CntW-1:0] LastBeat = CntW'(LineWords - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_DATA = 2'd1,
    SEND_ACK  = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  state_e                  state_q;
  logic [IdWidth-1:0]      id_q;
  logic [MstIdxBits-1:0]   first_q;
  logic                    shared_q;
  logic                    dirty_q;
  logic [NoMstPorts-1:0]   drain_pending_q;
  logic [NoMstPorts-1:0]   drain_pending_d;
  logic [CntW-1:0]         beat_cnt_q;
  mst_r_chan_t             r_q;
  logic                    r_valid_q;

  logic [AxiDataWidth-1:0] cd_word_s [NoMstPorts];
  logic [NoMstPorts-1:0]   cd_ready_s;
  logic [NoMstPorts-1:0]   drain_done_s;
  logic [NoMstPorts-1:0]   first_mask_s;
  logic                    fwd_hs_s;
  mst_r_chan_t             r_data_beat_s;
  mst_r_chan_t             r_ack_beat_s;

  // Only ar.id of the held request matters here.
  logic unused_req_s;
  assign unused_req_s = ^ccu_req_holder_i;

  // Split the flat CD data bus into per-port words.
  always_comb begin
    for (int i = 0; i < int'(NoMstPorts); i++) begin
      cd_word_s[i] = cd_data_i[i*AxiDataWidth +: AxiDataWidth];
    end
  end

  // One-hot mask of the incoming first responder, removed from the drain set.
  always_comb begin
    first_mask_s = '0;
    first_mask_s[first_responder_i] = 1'b1;
  end

  // CD ready generation, drain bookkeeping and forward-beat handshake.
  always_comb begin
    cd_ready_s   = '0;
    drain_done_s = '0;
    fwd_hs_s     = 1'b0;
    if ((state_q == SEND_DATA) || (state_q == DRAIN)) begin
      // Drained ports are always ready; their data is simply dropped.
      cd_ready_s   = drain_pending_q;
      drain_done_s = drain_pending_q & cd_valid_i & cd_last_i;
    end else begin
      cd_ready_s   = '0;
      drain_done_s = '0;
    end
    if (state_q == SEND_DATA) begin
      // Accept a forwarded beat only when the R register is free or emptying.
      cd_ready_s[first_q] = ~r_valid_q | r_ready_i;
      fwd_hs_s            = cd_valid_i[first_q] & (~r_valid_q | r_ready_i);
    end else begin
      fwd_hs_s = 1'b0;
    end
    drain_pending_d = drain_pending_q & ~drain_done_s;
  end

  // R beat contents for a forwarded data word and for the invalidate ack.
  always_comb begin
    r_data_beat_s      = '0;
    r_data_beat_s.id   = id_q;
    r_data_beat_s.data = cd_word_s[first_q];
    r_data_beat_s.resp = {shared_q, dirty_q, 2'b00};
    r_data_beat_s.last = (beat_cnt_q == LastBeat);

    r_ack_beat_s       = '0;
    r_ack_beat_s.id    = ccu_req_holder_i.ar.id;
    r_ack_beat_s.resp  = 4'b0000;
    r_ack_beat_s.last  = 1'b1;
  end

  // Control FSM together with the latched request fields and the R register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      id_q            <= '0;
      first_q         <= '0;
      shared_q        <= 1'b0;
      dirty_q         <= 1'b0;
      drain_pending_q <= '0;
      beat_cnt_q      <= '0;
      r_q             <= '0;
      r_valid_q       <= 1'b0;
    end else begin
      // A handshake empties the register; a load later in this block wins.
      if (r_valid_q && r_ready_i) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= r_valid_q;
      end
      drain_pending_q <= drain_pending_d;

      case (state_q)
        IDLE: begin
          if (su_valid_i) begin
            id_q       <= ccu_req_holder_i.ar.id;
            first_q    <= first_responder_i;
            shared_q   <= shared_i;
            dirty_q    <= dirty_i;
            beat_cnt_q <= '0;
            case (su_op_i)
              SEND_INVALID_ACK_R: begin
                // Data announced with an invalidating read belongs to the
                // write-back path, so nothing is drained here.
                drain_pending_q <= '0;
                r_q             <= r_ack_beat_s;
                r_valid_q       <= 1'b1;
                state_q         <= SEND_ACK;
              end
              READ_SNP_DATA: begin
                drain_pending_q <= data_available_i & ~first_mask_s;
                state_q         <= SEND_DATA;
              end
              default: begin
                drain_pending_q <= '0;
                state_q         <= IDLE;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end

        SEND_DATA: begin
          if (fwd_hs_s) begin
            r_q        <= r_data_beat_s;
            r_valid_q  <= 1'b1;
            beat_cnt_q <= beat_cnt_q + CntW'(1);
            // After the last CD beat, DRAIN also covers the case with nothing
            // left to drain: it then just waits for the last R handshake.
            if (beat_cnt_q == LastBeat) begin
              state_q <= DRAIN;
            end else begin
              state_q <= SEND_DATA;
            end
          end else begin
            state_q <= SEND_DATA;
          end
        end

        DRAIN: begin
          if ((drain_pending_d == '0) && (!r_valid_q || r_ready_i)) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end

        SEND_ACK: begin
          if (r_valid_q && r_ready_i) begin
            state_q <= IDLE;
          end else begin
            state_q <= SEND_ACK;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign su_ready_o = (state_q == IDLE);
  assign cd_ready_o = cd_ready_s;
  assign r_o        = r_q;
  assign r_valid_o  = r_valid_q;

endmodule

// File: tb/tb_ccu_ctrl_snoop_unit.sv
// Directed bench for ccu_ctrl_snoop_unit: a queue of expected R beats is built
// from the operation rules, and a compare process checks every R handshake.
module tb_ccu_ctrl_snoop_unit;
  import ccu_ctrl_snoop_unit_pkg::*;

  localparam int LINE_W = 128;
  localparam int DATA_W = 64;
  localparam int NPORTS = 4;
  localparam int SIDW   = 4;
  localparam int IDW    = 6;
  localparam int LW     = LINE_W / DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     su_valid_i = 1'b0;
  logic                     su_ready_o;
  su_op_e                   su_op_i = READ_SNP_DATA;
  def_req_t                 ccu_req_holder_i = '0;
  logic [NPORTS-1:0]        data_available_i = '0;
  logic [1:0]               first_responder_i = 2'd0;
  logic                     shared_i = 1'b0;
  logic                     dirty_i = 1'b0;
  logic [NPORTS-1:0]        cd_valid_i = '0;
  logic [NPORTS*DATA_W-1:0] cd_data_i = '0;
  logic [NPORTS-1:0]        cd_last_i = '0;
  logic [NPORTS-1:0]        cd_ready_o;
  def_r_chan_t              r_o;
  logic                     r_valid_o;
  logic                     r_ready_i = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  def_r_chan_t exp_q[$];
  def_r_chan_t rx_log[$];
  logic        hold_prev = 1'b0;
  def_r_chan_t prev_r;

  always #5 clk = ~clk;

  ccu_ctrl_snoop_unit #(
    .DcacheLineWidth(LINE_W),
    .AxiDataWidth   (DATA_W),
    .NoMstPorts     (NPORTS),
    .SlvAxiIDWidth  (SIDW),
    .mst_req_t      (def_req_t),
    .mst_r_chan_t   (def_r_chan_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .su_valid_i       (su_valid_i),
    .su_ready_o       (su_ready_o),
    .su_op_i          (su_op_i),
    .ccu_req_holder_i (ccu_req_holder_i),
    .data_available_i (data_available_i),
    .first_responder_i(first_responder_i),
    .shared_i         (shared_i),
    .dirty_i          (dirty_i),
    .cd_valid_i       (cd_valid_i),
    .cd_data_i        (cd_data_i),
    .cd_last_i        (cd_last_i),
    .cd_ready_o       (cd_ready_o),
    .r_o              (r_o),
    .r_valid_o        (r_valid_o),
    .r_ready_i        (r_ready_i)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic def_r_chan_t mk_beat(input logic [IDW-1:0] id, input logic [63:0] d,
                                          input logic [3:0] resp, input logic last);
    def_r_chan_t b;
    b      = '0;
    b.id   = id;
    b.data = d;
    b.resp = resp;
    b.last = last;
    return b;
  endfunction

  // Compare process: each R handshake must match the next expected beat, and a
  // stalled beat must not change.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (hold_prev) chk("r_stable", 128'(r_o), 128'(prev_r));
      if (r_valid_o && r_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("r_unexpected", 128'(r_o), 128'(0));
        end else begin
          chk("r_beat", 128'(r_o), 128'(exp_q.pop_front()));
        end
        rx_log.push_back(r_o);
      end
      hold_prev = r_valid_o && !r_ready_i;
      prev_r    = r_o;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // One operation; cycle 0 carries the su handshake, t counts cycles after it.
  task automatic do_snp(input logic ack, input logic [IDW-1:0] id, input int first,
                        input logic [3:0] avail, input logic sh, input logic dt,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input int drain_last, input int stall, input int exp_done);
    logic [63:0] beats [2];
    logic [3:0]  pdone;
    int          fk;
    int          done_at;
    beats[0] = b0;
    beats[1] = b1;
    pdone    = '0;
    fk       = 0;
    done_at  = -1;
    @(posedge clk); #1;
    su_valid_i          = 1'b1;
    su_op_i             = ack ? SEND_INVALID_ACK_R : READ_SNP_DATA;
    ccu_req_holder_i    = '0;
    ccu_req_holder_i.ar.id = id;
    first_responder_i   = first[1:0];
    data_available_i    = avail;
    shared_i            = sh;
    dirty_i             = dt;
    cd_valid_i          = '0;
    cd_last_i           = '0;
    cd_data_i           = '0;
    r_ready_i           = 1'b1;
    @(negedge clk);
    chk("su_ready_idle", 128'(su_ready_o), 128'(1));
    if (ack) exp_q.push_back(mk_beat(id, 64'h0, 4'b0000, 1'b1));
    else for (int k = 0; k < LW; k++) exp_q.push_back(mk_beat(id, beats[k], {sh, dt, 2'b00}, k == LW - 1));

    for (int t = 1; t <= 40 && done_at < 0; t++) begin
      @(posedge clk); #1;
      su_valid_i = (t == 1);   // still asserted while busy: must be ignored
      r_ready_i  = !(t >= 2 && t < 2 + stall);
      cd_valid_i = '0;
      cd_last_i  = '0;
      cd_data_i  = '0;
      cd_valid_i[3] = 1'b1;    // port 3 is never involved
      cd_last_i[3]  = 1'b1;
      cd_data_i[3*DATA_W +: DATA_W] = 64'hBAD3;
      for (int p = 0; p < 3; p++) begin
        if (ack) begin
          if (avail[p]) begin
            cd_valid_i[p] = 1'b1;
            cd_last_i[p]  = 1'b1;
            cd_data_i[p*DATA_W +: DATA_W] = 64'hAC0;
          end
        end else if (p == first) begin
          if (fk < LW) begin
            cd_valid_i[p] = 1'b1;
            cd_last_i[p]  = (fk == LW - 1);
            cd_data_i[p*DATA_W +: DATA_W] = beats[fk];
          end
        end else if (avail[p] && !pdone[p]) begin
          cd_valid_i[p] = 1'b1;
          cd_last_i[p]  = (t >= drain_last);
          cd_data_i[p*DATA_W +: DATA_W] = 64'hD0D0_0000 + 64'(p * 256 + t);
        end
      end
      @(negedge clk);
      chk("cd_ready_uninvolved", 128'(cd_ready_o[3]), 128'(0));
      if (ack) begin
        chk("cd_ready_ack", 128'(cd_ready_o), 128'(0));
      end else begin
        if (r_valid_o && !r_ready_i && fk < LW) chk("cd_ready_full", 128'(cd_ready_o[first]), 128'(0));
        if (cd_valid_i[first] && cd_ready_o[first]) fk++;
        for (int p = 0; p < 3; p++)
          if (p != first && avail[p] && cd_valid_i[p] && cd_ready_o[p] && cd_last_i[p]) pdone[p] = 1'b1;
      end
      if (su_ready_o) done_at = t;
    end
    chk("done_cycle", 128'(done_at), 128'(exp_done));
    chk("model_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_su_ready", 128'(su_ready_o), 128'(1));
    chk("rst_r_valid", 128'(r_valid_o), 128'(0));
    chk("rst_r_o", 128'(r_o), 128'(0));
    chk("rst_cd_ready", 128'(cd_ready_o), 128'(0));

    // Plain line forward, shared clean.
    rx_log.delete();
    do_snp(1'b0, 6'h25, 1, 4'b0010, 1'b1, 1'b0, 64'hA, 64'hB, 0, 0, 4);
    chk("pin_cnt", 128'(rx_log.size()), 128'(2));
    if (rx_log.size() == 2) begin
      chk("pin_b0_data", 128'(rx_log[0].data), 128'(64'hA));
      chk("pin_b0_resp", 128'(rx_log[0].resp), 128'(4'b1000));
      chk("pin_b0_last", 128'(rx_log[0].last), 128'(0));
      chk("pin_b0_id",   128'(rx_log[0].id),   128'(6'h25));
      chk("pin_b1_data", 128'(rx_log[1].data), 128'(64'hB));
      chk("pin_b1_last", 128'(rx_log[1].last), 128'(1));
    end

    // Backpressure on beat 0 for 3 cycles.
    do_snp(1'b0, 6'h11, 1, 4'b0010, 1'b1, 1'b0, 64'hC, 64'hD, 0, 3, 7);

    // Port 2 drained, its last beat 5 cycles after port 1's.
    rx_log.delete();
    do_snp(1'b0, 6'h07, 1, 4'b0110, 1'b0, 1'b0, 64'h1111, 64'h2222, 7, 0, 8);
    chk("drain_rx_cnt", 128'(rx_log.size()), 128'(2));

    // Invalidate ack, port 0 has write-back data.
    rx_log.delete();
    do_snp(1'b1, 6'h3A, 0, 4'b0001, 1'b1, 1'b1, 64'h0, 64'h0, 0, 0, 2);
    chk("pin_ack_cnt", 128'(rx_log.size()), 128'(1));
    if (rx_log.size() == 1) begin
      chk("pin_ack_data", 128'(rx_log[0].data), 128'(0));
      chk("pin_ack_resp", 128'(rx_log[0].resp), 128'(0));
      chk("pin_ack_last", 128'(rx_log[0].last), 128'(1));
      chk("pin_ack_id",   128'(rx_log[0].id),   128'(6'h3A));
    end

    // Dirty, not shared.
    rx_log.delete();
    do_snp(1'b0, 6'h2C, 0, 4'b0001, 1'b0, 1'b1, 64'hFEED, 64'hBEEF, 0, 0, 4);
    if (rx_log.size() == 2) begin
      chk("pin_dirty_resp0", 128'(rx_log[0].resp), 128'(4'b0100));
      chk("pin_dirty_resp1", 128'(rx_log[1].resp), 128'(4'b0100));
    end else begin
      chk("pin_dirty_cnt", 128'(rx_log.size()), 128'(2));
    end

    // Drain port finishing during SEND_DATA, with a one-cycle stall.
    do_snp(1'b0, 6'h01, 0, 4'b0011, 1'b1, 1'b1, 64'h55, 64'h66, 1, 1, 5);

    // Reset in the middle of a line after one of two beats.
    @(posedge clk); #1;
    su_valid_i = 1'b1;
    su_op_i    = READ_SNP_DATA;
    ccu_req_holder_i = '0;
    ccu_req_holder_i.ar.id = 6'h15;
    first_responder_i = 2'd1;
    data_available_i  = 4'b0010;
    shared_i = 1'b1;
    dirty_i  = 1'b0;
    r_ready_i = 1'b0;
    cd_valid_i = '0;
    @(posedge clk); #1;
    su_valid_i    = 1'b0;
    cd_valid_i[1] = 1'b1;
    cd_data_i[1*DATA_W +: DATA_W] = 64'h11;
    @(negedge clk);
    chk("mid_cd_ready", 128'(cd_ready_o[1]), 128'(1));
    @(posedge clk); #1;
    cd_valid_i = '0;
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_r_valid", 128'(r_valid_o), 128'(1));
    @(posedge clk); #1;
    rst_i = 1'b0;
    r_ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_su_ready", 128'(su_ready_o), 128'(1));
    chk("post_rst_r_valid", 128'(r_valid_o), 128'(0));
    chk("post_rst_r_o", 128'(r_o), 128'(0));
    chk("post_rst_cd_ready", 128'(cd_ready_o), 128'(0));
    do_snp(1'b0, 6'h33, 2, 4'b0100, 1'b0, 1'b0, 64'h77, 64'h88, 0, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
